// File: rtl/sand_brush.sv
// Square brush painter: writes a BRUSH_SIZE x BRUSH_SIZE block of cells into the
// simulation RAM, one cell per cycle, clipped at the screen edges.
module sand_brush #(
  parameter int                    ACTIVE_COLUMNS = 640,
  parameter int                    ACTIVE_ROWS    = 480,
  parameter int                    ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int                    DATA_WIDTH     = 2,
  parameter int                    X_WIDTH        = $clog2(ACTIVE_COLUMNS),
  parameter int                    Y_WIDTH        = $clog2(ACTIVE_ROWS),
  parameter int                    BRUSH_SIZE     = 4,
  parameter logic [DATA_WIDTH-1:0] SAND_VALUE     = 2'b01
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  draw_en_i,
  input  logic                  erase_i,
  input  logic [X_WIDTH-1:0]    cursor_x_i,
  input  logic [Y_WIDTH-1:0]    cursor_y_i,
  output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                  ram_wr_en_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int          CW   = (BRUSH_SIZE > 1) ? $clog2(BRUSH_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(BRUSH_SIZE - 1);

  typedef enum logic [1:0] {IDLE, PAINT, DONE} state_e;

  state_e                state_q, state_d;
  logic [X_WIDTH-1:0]    x0_q, x0_d;
  logic [Y_WIDTH-1:0]    y0_q, y0_d;
  logic                  erase_q, erase_d;
  logic [CW-1:0]         dx_q, dx_d;
  logic [CW-1:0]         dy_q, dy_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  // One extra bit so cells past the right/bottom edge are detected, not wrapped.
  logic [X_WIDTH:0] x_cell;
  logic [Y_WIDTH:0] y_cell;
  logic             cell_valid;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      erase_q    <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
      row_base_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      erase_q    <= erase_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      row_base_q <= row_base_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    erase_d    = erase_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    row_base_d = row_base_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    x_cell     = {1'b0, x0_q} + (X_WIDTH+1)'(dx_q);
    y_cell     = {1'b0, y0_q} + (Y_WIDTH+1)'(dy_q);
    cell_valid = (x_cell < (X_WIDTH+1)'(ACTIVE_COLUMNS)) &&
                 (y_cell < (Y_WIDTH+1)'(ACTIVE_ROWS));

    case (state_q)
      IDLE: begin
        if (draw_en_i) begin
          x0_d       = cursor_x_i;
          y0_d       = cursor_y_i;
          erase_d    = erase_i;
          dx_d       = '0;
          dy_d       = '0;
          // Constant multiply once per stroke; per-cell path is adders only.
          row_base_d = ADDR_WIDTH'(cursor_y_i) * ADDR_WIDTH'(ACTIVE_COLUMNS);
          state_d    = PAINT;
        end
      end
      PAINT: begin
        if (!draw_en_i) begin
          state_d = IDLE;
        end else begin
          wr_en_d = cell_valid;
          if (cell_valid) begin
            wr_addr_d = row_base_q + ADDR_WIDTH'(x_cell);
            wr_data_d = erase_q ? '0 : SAND_VALUE;
          end
          if (dx_q == LAST) begin
            dx_d       = '0;
            dy_d       = dy_q + CW'(1);
            row_base_d = row_base_q + ADDR_WIDTH'(ACTIVE_COLUMNS);
            if (dy_q == LAST) state_d = DONE;
          end else begin
            dx_d = dx_q + CW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ram_wr_address_o = wr_addr_q;
  assign ram_wr_data_o    = wr_data_q;
  assign ram_wr_en_o      = wr_en_q & draw_en_i;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DONE) & draw_en_i;

endmodule

// File: tb/tb_sand_brush.sv
// Scoreboard bench for sand_brush: stimulus queues expected writes/done pulses
// with their cycle numbers; a negedge monitor pops and compares.
module tb_sand_brush;

  localparam int COLS = 640;
  localparam int ROWS = 480;
  localparam int B    = 4;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        draw_en_i = 1'b0;
  logic        erase_i = 1'b0;
  logic [9:0]  cursor_x_i = '0;
  logic [8:0]  cursor_y_i = '0;
  logic [18:0] ram_wr_address_o;
  logic [1:0]  ram_wr_data_o;
  logic        ram_wr_en_o;
  logic        busy_o;
  logic        done_o;

  sand_brush dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .draw_en_i        (draw_en_i),
    .erase_i          (erase_i),
    .cursor_x_i       (cursor_x_i),
    .cursor_y_i       (cursor_y_i),
    .ram_wr_address_o (ram_wr_address_o),
    .ram_wr_data_o    (ram_wr_data_o),
    .ram_wr_en_o      (ram_wr_en_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit is_done;
    int addr;
    int data;
  } evt_t;

  evt_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_evt(input bit is_done, input int addr, input int data);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: got addr %0d data %0d at cycle %0d, expected nothing",
               is_done ? "done" : "write", addr, data, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.is_done != is_done || e.cyc != cyc ||
        (!is_done && (e.addr != addr || e.data != data))) begin
      failures++;
      $display("FAIL event: got %s cyc %0d addr %0d data %0d, expected %s cyc %0d addr %0d data %0d",
               is_done ? "done" : "write", cyc, addr, data,
               e.is_done ? "done" : "write", e.cyc, e.addr, e.data);
    end
  endtask

  always @(negedge clk_i) begin
    if (ram_wr_en_o) check_evt(1'b0, int'(ram_wr_address_o), int'(ram_wr_data_o));
    if (done_o)      check_evt(1'b1, 0, 0);
  end

  // Drive a stroke in the current cycle N and queue the first `limit` cells.
  task automatic launch(input int x, input int y, input bit er, input int limit);
    int n, cx, cy;
    cursor_x_i = 10'(x);
    cursor_y_i = 9'(y);
    erase_i    = er;
    draw_en_i  = 1'b1;
    n = cyc;
    for (int k = 0; k < limit; k++) begin
      cx = x + (k % B);
      cy = y + (k / B);
      if (cx < COLS && cy < ROWS)
        exp_q.push_back('{n + 2 + k, 1'b0, cy * COLS + cx, er ? 0 : 1});
    end
    if (limit == B * B) exp_q.push_back('{n + 1 + B * B, 1'b1, 0, 0});
  endtask

  // Full stroke; cursor/erase are disturbed mid-stroke and must be ignored.
  task automatic stroke(input int x, input int y, input bit er, input bit hold);
    launch(x, y, er, B * B);
    repeat (6) @(posedge clk_i);
    #1;
    cursor_x_i = 10'(x ^ 5);
    cursor_y_i = 9'(y ^ 3);
    erase_i    = ~er;
    repeat (B * B + 2 - 6) @(posedge clk_i);
    #1;
    if (!hold) draw_en_i = 1'b0;
  endtask

  initial begin
    #2;
    check_val("rst_addr", int'(ram_wr_address_o), 0);
    check_val("rst_data", int'(ram_wr_data_o), 0);
    check_val("rst_en", int'(ram_wr_en_o), 0);
    check_val("rst_busy", int'(busy_o), 0);
    check_val("rst_done", int'(done_o), 0);
    repeat (2) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // Back-to-back strokes: each relatches at N+18.
    stroke(10, 20, 1'b0, 1'b1);
    stroke(638, 478, 1'b0, 1'b1);
    stroke(0, 0, 1'b1, 1'b1);
    stroke(700, 5, 1'b0, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    check_val("idle_busy", int'(busy_o), 0);

    // Abort after the 5th write output.
    launch(10, 20, 1'b0, 5);
    repeat (7) @(posedge clk_i);
    #1 draw_en_i = 1'b0;
    #1;
    check_val("abort_en_gated", int'(ram_wr_en_o), 0);
    check_val("abort_busy_still", int'(busy_o), 1);
    @(posedge clk_i);
    #1;
    check_val("abort_idle", int'(busy_o), 0);
    stroke(100, 100, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;

    // Asynchronous reset mid-stroke.
    launch(200, 300, 1'b0, 2);
    repeat (4) @(posedge clk_i);
    #1 reset_ni = 1'b0;
    #1;
    check_val("midrst_addr", int'(ram_wr_address_o), 0);
    check_val("midrst_data", int'(ram_wr_data_o), 0);
    check_val("midrst_en", int'(ram_wr_en_o), 0);
    check_val("midrst_busy", int'(busy_o), 0);
    check_val("midrst_done", int'(done_o), 0);
    @(posedge clk_i);
    #1 draw_en_i = 1'b0;
    @(posedge clk_i);
    #1 reset_ni = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    check_val("post_rst_busy", int'(busy_o), 0);
    stroke(10, 20, 1'b0, 1'b0);

    repeat (5) @(posedge clk_i);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: got %0d left in queue, expected 0 (first cyc %0d addr %0d)",
               exp_q.size(), exp_q[0].cyc, exp_q[0].addr);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sand_brush.md
# sand_brush

Paints a square brush of sand (or empty) cells into the simulation RAM at the latched cursor position while painting is permitted. Sits directly downstream of the game state controller's `draw_en_o`, which is high only during the WAIT window when the controller does not own the RAM. Drives the RAM write port through the top-level write mux during that window. Clips at screen edges and releases the port the same cycle `draw_en_i` falls.

## Interface
- `ACTIVE_COLUMNS`, 640, grid width in cells
- `ACTIVE_ROWS`, 480, grid height in cells
- `ADDR_WIDTH`, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), RAM address width
- `DATA_WIDTH`, 2, cell state width
- `X_WIDTH`, $clog2(ACTIVE_COLUMNS), cursor x width
- `Y_WIDTH`, $clog2(ACTIVE_ROWS), cursor y width
- `BRUSH_SIZE`, 4, brush side length in cells (≥1)
- `SAND_VALUE`, 2'b01, cell code written when painting
- `clk_i` in 1 — single clock
- `reset_ni` in 1 — reset, asynchronous, active-low
- `draw_en_i` in 1 — paint permitted (controller `draw_en_o`)
- `erase_i` in 1 — 1: write 0 (empty) instead of `SAND_VALUE`
- `cursor_x_i` in X_WIDTH — brush top-left column
- `cursor_y_i` in Y_WIDTH — brush top-left row
- `ram_wr_address_o` out ADDR_WIDTH — y*ACTIVE_COLUMNS+x
- `ram_wr_data_o` out DATA_WIDTH — cell value
- `ram_wr_en_o` out 1 — write strobe
- `busy_o` out 1 — stroke in progress (state ≠ IDLE)
- `done_o` out 1 — one-cycle stroke-complete pulse

## Operation
- States: IDLE, PAINT, DONE.
- IDLE: if `draw_en_i`=1, latch x0, y0, erase; clear dx, dy, row_base = y0*ACTIVE_COLUMNS (computed once at latch, or incrementally); go to PAINT.
- PAINT: one cell per cycle, row-major (dx fastest). x = x0+dx, y = y0+dy, computed in X_WIDTH+1 / Y_WIDTH+1 bits (no wrap). Cell is valid iff x < ACTIVE_COLUMNS and y < ACTIVE_ROWS.
  - Valid cell: load write regs with en=1, addr=row_base+x, data = erase ? 0 : SAND_VALUE.
  - Invalid cell: load en=0, still consumes its cycle.
  - At dx=BRUSH_SIZE-1: dx←0, dy+1, row_base += ACTIVE_COLUMNS. After cell (B-1,B-1), go to DONE.
- DONE: write regs load en=0; go to IDLE.
- Abort: `draw_en_i`=0 in PAINT or DONE → next state IDLE, write en reg cleared, no `done_o`.
- Cursor and erase changes after latch are ignored until the next stroke.
- `draw_en_i` held high continuously repaints strokes back to back with the cursor re-latched each time.
- Address arithmetic uses adders only (no multiplier in the per-cell path); address is ADDR_WIDTH bits.

## Timing
- Reset (async, `reset_ni`=0): state IDLE, all counters 0, write regs 0. `ram_wr_address_o`=0, `ram_wr_data_o`=0, `ram_wr_en_o`=0, `busy_o`=0, `done_o`=0.
- Write outputs are registered.
- `ram_wr_en_o` = en_reg AND `draw_en_i` (combinational gate), so the port is released the same cycle `draw_en_i` falls.
- Latch at edge ending cycle N. Cell k (0..B²-1) is computed in cycle N+1+k and appears on the outputs in cycle N+2+k.
- `done_o` = (state==DONE) AND `draw_en_i`. It is high in cycle N+1+B², coincident with the last cell's output.
- IDLE is reached in cycle N+2+B², and a new latch may occur that cycle. Stroke period is B²+2 cycles.

## Test plan
- Cursor (10,20), B=4, `draw_en_i` held → 16 writes, data 01, addresses 12810–12813, 13450–13453, 14090–14093, 14730–14733 on consecutive cycles starting N+2; `done_o` one pulse at N+17, with the next stroke latching at N+18.
- Cursor (638,478) → only 306558, 306559, 307198, 307199 written; the other 12 cycles have en=0; `done_o` timing unchanged.
- `erase_i`=1, cursor (0,0) → 16 writes, data 0, addresses 0–3, 640–643, 1280–1283, 1920–1923.
- `draw_en_i` dropped after the 5th write output → `ram_wr_en_o` low that same cycle, IDLE next cycle, no `done_o`. Re-raise at cursor (100,100) → the stroke restarts at address 64100.
- Cursor x=700 (out of range) → zero writes, `done_o` still pulses at N+17. Changing the cursor mid-stroke does not alter addresses.
- `reset_ni` asserted mid-stroke → all outputs 0 immediately. After release, no writes until `draw_en_i` is sampled high in IDLE.
